// File: rtl/sort4_sched_pkg.sv
// Shared types and helpers for the sort4_sched round-robin sort scheduler.
package sort4_sched_pkg;

  localparam int MAX_IDW = 2;
  localparam int KEY_W   = 8;

  function automatic int idw_f(input int nreq);
    return (nreq <= 2) ? 1 : $clog2(nreq);
  endfunction

  // Sized for the widest legal requester count; narrower builds truncate.
  typedef struct packed {
    logic               valid;
    logic [MAX_IDW-1:0] id;
  } tag_t;

  typedef logic [3:0][KEY_W-1:0] keys_t;

endpackage

// File: rtl/compare.sv
// Non-stallable 4-key ascending sort pipeline, 5 clocks from input to output, no reset.
module compare #(
  parameter int DWIDTH = 8
) (
  input  logic                clk,
  input  logic [4*DWIDTH-1:0] in_keys,
  output logic [4*DWIDTH-1:0] out_keys
);

  typedef logic [3:0][DWIDTH-1:0] arr_t;

  arr_t keys_p0, keys_p1, keys_p2, keys_p3, keys_p4;

  function automatic arr_t cswap(input arr_t a, input int i, input int j);
    arr_t r;
    r = a;
    if (a[j] < a[i]) begin
      r[i] = a[j];
      r[j] = a[i];
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    // p0: capture
    keys_p0 <= in_keys;
    // p1: adjacent pairs
    keys_p1 <= cswap(cswap(keys_p0, 0, 1), 2, 3);
    // p2: min and max settle at the ends
    keys_p2 <= cswap(cswap(keys_p1, 0, 2), 1, 3);
    // p3: middle pair
    keys_p3 <= cswap(keys_p2, 1, 2);
    // p4: output register
    keys_p4 <= keys_p3;
  end

  assign out_keys = keys_p4;

endmodule

// File: rtl/sort4_sched_rr_arb.sv
// sort4_rr_arb: NREQ-way round-robin arbiter; pointer advances past the winner on handshake.
module sort4_rr_arb
  import sort4_sched_pkg::*;
#(
  parameter  int NREQ = 2,
  localparam int IDW  = idw_f(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_valid,
  input  logic            hs,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_id,
  output logic            grant_any
);

  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [NREQ-1:0] hi_valid;
  logic [IDW-1:0]  hi_id, lo_id;

  // Requesters at or above the pointer win first; otherwise wrap to the lowest.
  always_comb begin
    hi_valid = '0;
    hi_id    = '0;
    lo_id    = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      hi_valid[j] = req_valid[j] && (j >= int'(ptr_q));
      if (req_valid[j]) lo_id = IDW'(j);
      if (hi_valid[j])  hi_id = IDW'(j);
    end
    grant_any = |req_valid;
    grant_id  = (|hi_valid) ? hi_id : lo_id;
    grant     = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (grant_any && grant_id == IDW'(j)) grant[j] = 1'b1;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (hs) ptr_d = (int'(grant_id) == NREQ - 1) ? '0 : grant_id + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/sort4_sched.sv
// sort4_sched: shares one compare pipeline between NREQ requesters with credit-gated issue.
// Optional SORT4_SCHED_STATS_EN adds saturating grant/stall counters.
module sort4_sched
  import sort4_sched_pkg::*;
#(
  parameter  int DWIDTH     = 8,
  parameter  int NREQ       = 2,
  parameter  int SORT_LAT   = 5,
  parameter  int FIFO_DEPTH = 8,
  localparam int IDW        = idw_f(NREQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*4*DWIDTH-1:0] req_keys,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [4*DWIDTH-1:0]      res_keys,
  output logic [IDW-1:0]           res_id
`ifdef SORT4_SCHED_STATS_EN
  ,
  output logic [NREQ*16-1:0]       grant_cnt,
  output logic [15:0]              stall_cnt
`endif
);

  localparam int KW = 4 * DWIDTH;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_id;
  logic            grant_any;
  logic            issue_ok, hs, push, pop;
  logic [KW-1:0]   key_sel, cmp_in, cmp_in_q, cmp_out;
  tag_t            tag_d;
  tag_t            tag_p [SORT_LAT];

  logic [CW-1:0]   used_q, used_d, cnt_q, cnt_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [KW-1:0]   mem_keys [FIFO_DEPTH];
  logic [IDW-1:0]  mem_id   [FIFO_DEPTH];

  sort4_rr_arb #(.NREQ(NREQ)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .hs        (hs),
    .grant     (grant),
    .grant_id  (grant_id),
    .grant_any (grant_any)
  );

  // Every issued job holds a FIFO slot from issue until it is popped.
  assign issue_ok  = !rst && (used_q < CW'(FIFO_DEPTH));
  assign hs        = grant_any && issue_ok;
  assign req_ready = issue_ok ? grant : '0;

  always_comb begin
    key_sel = '0;
    for (int r = 0; r < NREQ; r++) begin
      if (grant_id == IDW'(r)) key_sel = req_keys[r*KW +: KW];
    end
  end

  assign cmp_in = hs ? key_sel : cmp_in_q;

  compare #(.DWIDTH(DWIDTH)) u_compare (
    .clk      (clk),
    .in_keys  (cmp_in),
    .out_keys (cmp_out)
  );

  always_comb begin
    tag_d.valid = hs;
    tag_d.id    = MAX_IDW'(grant_id);
  end

  assign push      = tag_p[SORT_LAT-1].valid;
  assign res_valid = (cnt_q != '0);
  assign pop       = res_valid && res_ready;
  assign res_keys  = res_valid ? mem_keys[rd_ptr_q] : '0;
  assign res_id    = res_valid ? mem_id[rd_ptr_q] : '0;

  always_comb begin
    used_d = used_q;
    if (hs)  used_d = used_d + 1'b1;
    if (pop) used_d = used_d - 1'b1;
    cnt_d = cnt_q;
    if (push) cnt_d = cnt_d + 1'b1;
    if (pop)  cnt_d = cnt_d - 1'b1;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      used_q   <= '0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      used_q   <= used_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Tag pipe: stage SORT_LAT-1 lines up with the compare output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SORT_LAT; s++) tag_p[s] <= '0;
    end else begin
      tag_p[0] <= tag_d;
      for (int s = 1; s < SORT_LAT; s++) tag_p[s] <= tag_p[s-1];
    end
  end

  always_ff @(posedge clk) begin
    cmp_in_q <= cmp_in;
    if (push) begin
      mem_keys[wr_ptr_q] <= cmp_out;
      mem_id[wr_ptr_q]   <= IDW'(tag_p[SORT_LAT-1].id);
    end
  end

`ifdef SORT4_SCHED_STATS_EN
  logic [15:0] grant_cnt_q [NREQ];
  logic [15:0] grant_cnt_d [NREQ];
  logic [15:0] stall_cnt_q, stall_cnt_d;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    for (int r = 0; r < NREQ; r++) begin
      grant_cnt_d[r] = (hs && grant_id == IDW'(r)) ? sat_inc16(grant_cnt_q[r]) : grant_cnt_q[r];
    end
    stall_cnt_d = ((|req_valid) && !issue_ok) ? sat_inc16(stall_cnt_q) : stall_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREQ; r++) grant_cnt_q[r] <= '0;
      stall_cnt_q <= '0;
    end else begin
      for (int r = 0; r < NREQ; r++) grant_cnt_q[r] <= grant_cnt_d[r];
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int r = 0; r < NREQ; r++) grant_cnt[r*16 +: 16] = grant_cnt_q[r];
  end
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_sort4_sched.sv
// Directed bench for sort4_sched (NREQ=2, DWIDTH=8) with a result scoreboard.
module tb_sort4_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_keys;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_keys;
  logic        res_id;
`ifdef SORT4_SCHED_STATS_EN
  logic [31:0] grant_cnt;
  logic [15:0] stall_cnt;
`endif

  sort4_sched #(.DWIDTH(8), .NREQ(2), .SORT_LAT(5), .FIFO_DEPTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_keys  (req_keys),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_keys  (res_keys),
    .res_id    (res_id)
`ifdef SORT4_SCHED_STATS_EN
    ,
    .grant_cnt (grant_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard entries are {id, sorted keys}, pushed at handshake in issue order.
  logic [32:0] exp_q [$];
  logic [32:0] exp_e;
  logic [31:0] exp_sorted [2];
  int hs_cnt = 0, pop_cnt = 0, resv_cycles = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (res_valid && res_ready) begin
        pop_cnt++;
        if (exp_q.size() == 0) begin
          chk("sb_nonempty", 64'(exp_q.size()), 64'd1);
        end else begin
          exp_e = exp_q.pop_front();
          chk("res_id", 64'(res_id), 64'(exp_e[32]));
          chk("res_keys", 64'(res_keys), 64'(exp_e[31:0]));
        end
      end
      if (|(req_valid & req_ready)) begin
        hs_cnt++;
        exp_q.push_back({req_ready[1], req_ready[1] ? exp_sorted[1] : exp_sorted[0]});
      end
      if (res_valid) resv_cycles++;
    end
  end

  task automatic drain();
    int i;
    for (i = 0; i < 80; i++) begin
      @(negedge clk);
      if (!res_valid && exp_q.size() == 0) break;
    end
    if (i == 80) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic issue_one(input int r, input logic [31:0] keys, input logic [31:0] sorted);
    int i;
    @(posedge clk); #1;
    if (r == 0) begin req_keys[31:0] = keys;  exp_sorted[0] = sorted; req_valid = 2'b01; end
    else        begin req_keys[63:32] = keys; exp_sorted[1] = sorted; req_valid = 2'b10; end
    for (i = 0; i < 30; i++) begin
      @(negedge clk);
      if ((req_ready & req_valid) != 2'b00) break;
    end
    if (i == 30) chk("issue_timeout", 64'(req_ready), 64'(req_valid));
    @(posedge clk); #1;
    req_valid = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, hs0, p0, rv0;
    logic [1:0] eg;
    rst = 1'b1;
    req_valid = 2'b11;
    res_ready = 1'b1;
    req_keys = '0;
    exp_sorted[0] = '0;
    exp_sorted[1] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_id", 64'(res_id), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = 2'b00;

    // Single job from req0: keys 7,3,9,1 -> 1,3,7,9
    @(posedge clk); #1;
    req_keys[31:0] = 32'h01090307;
    exp_sorted[0]  = 32'h09070301;
    req_valid = 2'b01;
    @(negedge clk);
    chk("t1_ready", 64'(req_ready), 64'd1);
    lat = 0;
    @(posedge clk); #1;
    req_valid = 2'b00;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (res_valid) break;
    end
    chk("t1_latency", 64'(lat), 64'd6);
    chk("t1_keys", 64'(res_keys), 64'h09070301);
    chk("t1_id", 64'(res_id), 64'd0);
    @(negedge clk);
    chk("t1_empty", 64'(res_valid), 64'd0);

    // Both requesters streaming; pointer sits at 1 after the req0 handshake
    req_keys[63:32] = 32'h20301040;
    exp_sorted[1]   = 32'h40302010;
    hs0 = hs_cnt;
    p0  = pop_cnt;
    @(posedge clk); #1;
    req_valid = 2'b11;
    eg = 2'b10;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t2_grant", 64'(req_ready), 64'(eg));
      eg = ~eg;
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    drain();
    chk("t2_hs", 64'(hs_cnt - hs0), 64'd8);
    chk("t2_pops", 64'(pop_cnt - p0), 64'd8);

    // Back-pressure: credits stop issue at FIFO_DEPTH
    hs0 = hs_cnt;
    p0  = pop_cnt;
    @(posedge clk); #1;
    res_ready = 1'b0;
    req_valid = 2'b01;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("t3_hs", 64'(hs_cnt - hs0), 64'd8);
    chk("t3_ready", 64'(req_ready), 64'd0);
    chk("t3_res_valid", 64'(res_valid), 64'd1);
    chk("t3_no_pop", 64'(pop_cnt - p0), 64'd0);
    @(posedge clk); #1;
    res_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("t3_resume", 64'(hs_cnt - hs0 > 8), 64'd1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    drain();
    chk("t3_drain", 64'(pop_cnt - p0), 64'(hs_cnt - hs0));

    // Ties and extremes
    issue_one(0, 32'h05050505, 32'h05050505);
    issue_one(1, 32'h00FF00FF, 32'hFFFF0000);
    drain();

    // Reset with three jobs in flight
    @(posedge clk); #1;
    req_keys[31:0] = 32'h01090307;
    exp_sorted[0]  = 32'h09070301;
    req_valid = 2'b01;
    repeat (3) @(posedge clk);
    #1;
    req_valid = 2'b00;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    rv0 = resv_cycles;
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("t5_no_res", 64'(resv_cycles - rv0), 64'd0);
    @(posedge clk); #1;
    req_keys[31:0]  = 32'h05050505;
    exp_sorted[0]   = 32'h05050505;
    req_valid = 2'b11;
    @(negedge clk);
    chk("t5_ptr", 64'(req_ready), 64'd1);
    p0 = pop_cnt;
    @(posedge clk); #1;
    req_valid = 2'b00;
    drain();
    chk("t5_after", 64'(pop_cnt - p0), 64'd1);

`ifdef SORT4_SCHED_STATS_EN
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("st_clr_grant", 64'(grant_cnt), 64'd0);
    chk("st_clr_stall", 64'(stall_cnt), 64'd0);
    issue_one(1, 32'h20301040, 32'h40302010);
    issue_one(1, 32'h20301040, 32'h40302010);
    drain();
    @(posedge clk); #1;
    res_ready = 1'b0;
    req_valid = 2'b10;
    repeat (12) @(posedge clk);
    #1;
    req_valid = 2'b00;
    @(negedge clk);
    chk("st_grant1", 64'(grant_cnt[31:16]), 64'd10);
    chk("st_grant0", 64'(grant_cnt[15:0]), 64'd0);
    chk("st_stall", 64'(stall_cnt), 64'd4);
    @(posedge clk); #1;
    res_ready = 1'b1;
    drain();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
